// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
package mem_arb_pkg;

   localparam int unsigned AddrWDefault   = 32;
   localparam int unsigned DataWDefault   = 512;
   localparam int unsigned TimeoutDefault = 255;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDone
   } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and MEM-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault
) ();

   logic              read_r0;
   logic              write_r0;
   logic [ADDR_W-1:0] addr_r0;
   logic [DATA_W-1:0] wdata_r0;
   logic              read_r1;
   logic              write_r1;
   logic [ADDR_W-1:0] addr_r1;
   logic [DATA_W-1:0] wdata_r1;
   logic              ready_r0;
   logic              ready_r1;
   logic [DATA_W-1:0] rdata_out;
   logic              read_L2_MEM;
   logic              write_L2_MEM;
   logic [ADDR_W-1:0] addr_L2_MEM;
   logic [DATA_W-1:0] write_data_L2_MEM;
   logic              ready_MEM_L2;
   logic [DATA_W-1:0] read_data_MEM_L2;
   logic              timeout_err;

   modport slave (
      input  read_r0, write_r0, addr_r0, wdata_r0,
      input  read_r1, write_r1, addr_r1, wdata_r1,
      input  ready_MEM_L2, read_data_MEM_L2,
      output ready_r0, ready_r1, rdata_out,
      output read_L2_MEM, write_L2_MEM, addr_L2_MEM, write_data_L2_MEM,
      output timeout_err
   );

   modport master (
      output read_r0, write_r0, addr_r0, wdata_r0,
      output read_r1, write_r1, addr_r1, wdata_r1,
      output ready_MEM_L2, read_data_MEM_L2,
      input  ready_r0, ready_r1, rdata_out,
      input  read_L2_MEM, write_L2_MEM, addr_L2_MEM, write_data_L2_MEM,
      input  timeout_err
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on a tie the requester
// not served last wins. Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      unique case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two line-sized requesters onto one MEM port with a bounded
// wait for MEM ready. All outputs are registered.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = AddrWDefault,
   parameter int unsigned DATA_W  = DataWDefault,
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input logic            clk,
   input logic            rstn,
   mem_arbiter_if.slave   bus_io
);

   localparam int unsigned    CntW       = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt_idx_q, gnt_idx_d;
   logic              is_write_q, is_write_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_r0_q, ready_r0_d;
   logic              ready_r1_q, ready_r1_d;
   logic              timeout_q, timeout_d;

   logic [1:0]        req;
   logic [1:0]        grant;
   logic [CntW-1:0]   wait_inc;
   logic              sel_write;

   assign req = {bus_io.read_r1 | bus_io.write_r1, bus_io.read_r0 | bus_io.write_r0};

   rr_arb2 u_rr_arb2 (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign wait_inc  = wait_cnt_q + CntW'(1);
   // Write wins when a requester raises read and write together.
   assign sel_write = grant[1] ? bus_io.write_r1 : bus_io.write_r0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_idx_d    = gnt_idx_q;
      is_write_d   = is_write_q;
      wait_cnt_d   = wait_cnt_q;
      mem_rd_d     = mem_rd_q;
      mem_wr_d     = mem_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ready_r0_d   = 1'b0;
      ready_r1_d   = 1'b0;
      timeout_d    = timeout_q;

      unique case (state_q)
         StIdle: begin
            if (grant != 2'b00) begin
               gnt_idx_d    = grant[1];
               last_grant_d = grant[1];
               is_write_d   = sel_write;
               mem_wr_d     = sel_write;
               mem_rd_d     = ~sel_write;
               addr_d       = grant[1] ? bus_io.addr_r1  : bus_io.addr_r0;
               wdata_d      = grant[1] ? bus_io.wdata_r1 : bus_io.wdata_r0;
               wait_cnt_d   = '0;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            if (bus_io.ready_MEM_L2 || wait_inc == TimeoutCnt) begin
               mem_rd_d   = 1'b0;
               mem_wr_d   = 1'b0;
               ready_r0_d = ~gnt_idx_q;
               ready_r1_d = gnt_idx_q;
               state_d    = StDone;
               if (bus_io.ready_MEM_L2) begin
                  if (!is_write_q) rdata_d = bus_io.read_data_MEM_L2;
               end else begin
                  wait_cnt_d = wait_inc;
                  timeout_d  = 1'b1;
                  rdata_d    = '0;
               end
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         gnt_idx_q    <= 1'b0;
         is_write_q   <= 1'b0;
         wait_cnt_q   <= '0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         ready_r0_q   <= 1'b0;
         ready_r1_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_idx_q    <= gnt_idx_d;
         is_write_q   <= is_write_d;
         wait_cnt_q   <= wait_cnt_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ready_r0_q   <= ready_r0_d;
         ready_r1_q   <= ready_r1_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus_io.ready_r0          = ready_r0_q;
   assign bus_io.ready_r1          = ready_r1_q;
   assign bus_io.rdata_out         = rdata_q;
   assign bus_io.read_L2_MEM       = mem_rd_q;
   assign bus_io.write_L2_MEM      = mem_wr_q;
   assign bus_io.addr_L2_MEM       = addr_q;
   assign bus_io.write_data_L2_MEM = wdata_q;
   assign bus_io.timeout_err       = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lone read, tie, repeated write ready,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   localparam logic [63:0] DataA = 64'hA5A5_0000_1111_2222;
   localparam logic [63:0] DataB = 64'hB0B0_3333_4444_5555;
   localparam logic [63:0] DataC = 64'hC1C1_6666_7777_8888;
   localparam logic [63:0] DataD = 64'hD2D2_9999_AAAA_BBBB;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;
   int   cyc;
   int   t0;
   int   t1;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (4)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rstn     = 1'b0;
      bus.read_r0 = 1'b0;  bus.write_r0 = 1'b0;  bus.addr_r0 = '0;  bus.wdata_r0 = '0;
      bus.read_r1 = 1'b0;  bus.write_r1 = 1'b0;  bus.addr_r1 = '0;  bus.wdata_r1 = '0;
      bus.ready_MEM_L2 = 1'b0;
      bus.read_data_MEM_L2 = '0;
      tick();
      tick();

      // Reset state
      chk("rst_ready_r0", bus.ready_r0, 0);
      chk("rst_read_mem", bus.read_L2_MEM, 0);
      chk("rst_write_mem", bus.write_L2_MEM, 0);
      chk("rst_addr", bus.addr_L2_MEM, 0);
      chk("rst_rdata", bus.rdata_out, 0);
      chk("rst_timeout", bus.timeout_err, 0);

      // Lone read from r0, MEM ready one cycle after the request
      rstn = 1'b1;
      bus.read_r0 = 1'b1;
      bus.addr_r0 = 32'h100;
      tick();
      chk("lone_read_mem", bus.read_L2_MEM, 1);
      chk("lone_addr", bus.addr_L2_MEM, 64'h100);
      chk("lone_no_ready", bus.ready_r0, 0);
      bus.ready_MEM_L2 = 1'b1;
      bus.read_data_MEM_L2 = DataA;
      tick();
      chk("lone_ready_r0", bus.ready_r0, 1);
      chk("lone_ready_r1", bus.ready_r1, 0);
      chk("lone_read_drop", bus.read_L2_MEM, 0);
      chk("lone_rdata", bus.rdata_out, DataA);
      bus.ready_MEM_L2 = 1'b0;
      bus.read_r0 = 1'b0;
      tick();
      chk("lone_ready_once", bus.ready_r0, 0);
      chk("lone_idle_mem", bus.read_L2_MEM, 0);

      // Tie right after reset: r0 first, then r1
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      bus.read_r0 = 1'b1;  bus.addr_r0 = 32'h200;
      bus.read_r1 = 1'b1;  bus.addr_r1 = 32'h300;
      tick();
      chk("tie_first_addr", bus.addr_L2_MEM, 64'h200);
      bus.ready_MEM_L2 = 1'b1;
      bus.read_data_MEM_L2 = DataB;
      tick();
      chk("tie_r0_ready", bus.ready_r0, 1);
      chk("tie_r1_not_yet", bus.ready_r1, 0);
      chk("tie_rdata_b", bus.rdata_out, DataB);
      t0 = cyc;
      bus.ready_MEM_L2 = 1'b0;
      bus.read_r0 = 1'b0;
      tick();
      chk("tie_idle_read", bus.read_L2_MEM, 0);
      tick();
      chk("tie_second_addr", bus.addr_L2_MEM, 64'h300);
      chk("tie_second_read", bus.read_L2_MEM, 1);
      bus.ready_MEM_L2 = 1'b1;
      bus.read_data_MEM_L2 = DataC;
      tick();
      chk("tie_r1_ready", bus.ready_r1, 1);
      chk("tie_r0_quiet", bus.ready_r0, 0);
      t1 = cyc;
      chk("tie_gap", 64'((t1 - t0) >= 3), 1);
      bus.ready_MEM_L2 = 1'b0;
      bus.read_r1 = 1'b0;
      tick();

      // Write from r1 with MEM ready held high throughout
      bus.write_r1 = 1'b1;
      bus.addr_r1  = 32'h400;
      bus.wdata_r1 = DataD;
      bus.ready_MEM_L2 = 1'b1;
      bus.read_data_MEM_L2 = DataA;
      tick();
      chk("wr_write_mem", bus.write_L2_MEM, 1);
      chk("wr_read_low", bus.read_L2_MEM, 0);
      chk("wr_wdata", bus.write_data_L2_MEM, DataD);
      tick();
      chk("wr_ready_r1", bus.ready_r1, 1);
      chk("wr_write_drop", bus.write_L2_MEM, 0);
      chk("wr_rdata_kept", bus.rdata_out, DataC);
      bus.write_r1 = 1'b0;
      tick();
      chk("wr_no_extra_1", bus.ready_r1, 0);
      chk("wr_mem_low_1", bus.write_L2_MEM, 0);
      tick();
      chk("wr_no_extra_2", bus.ready_r1, 0);
      bus.ready_MEM_L2 = 1'b0;

      // Read and write together: must become a write
      bus.read_r0  = 1'b1;
      bus.write_r0 = 1'b1;
      bus.addr_r0  = 32'h480;
      tick();
      chk("rw_is_write", bus.write_L2_MEM, 1);
      chk("rw_not_read", bus.read_L2_MEM, 0);
      bus.ready_MEM_L2 = 1'b1;
      tick();
      chk("rw_ready_r0", bus.ready_r0, 1);
      bus.ready_MEM_L2 = 1'b0;
      bus.read_r0  = 1'b0;
      bus.write_r0 = 1'b0;
      tick();

      // Timeout with MEM silent: four ISSUE cycles then DONE
      bus.read_r0 = 1'b1;
      bus.addr_r0 = 32'h500;
      tick();
      chk("to_issue_1", bus.read_L2_MEM, 1);
      tick();
      tick();
      tick();
      chk("to_issue_4", bus.read_L2_MEM, 1);
      chk("to_not_yet", bus.timeout_err, 0);
      tick();
      chk("to_err", bus.timeout_err, 1);
      chk("to_ready_r0", bus.ready_r0, 1);
      chk("to_rdata_zero", bus.rdata_out, 0);
      chk("to_mem_drop", bus.read_L2_MEM, 0);
      bus.read_r0 = 1'b0;
      tick();
      chk("to_sticky", bus.timeout_err, 1);
      chk("to_ready_once", bus.ready_r0, 0);

      // Reset during ISSUE aborts with no ready; next tie goes to r0
      bus.read_r1 = 1'b1;
      bus.addr_r1 = 32'h600;
      bus.wdata_r1 = DataB;
      tick();
      chk("ab_issue", bus.read_L2_MEM, 1);
      rstn = 1'b0;
      tick();
      chk("ab_read_mem", bus.read_L2_MEM, 0);
      chk("ab_write_mem", bus.write_L2_MEM, 0);
      chk("ab_addr", bus.addr_L2_MEM, 0);
      chk("ab_wdata", bus.write_data_L2_MEM, 0);
      chk("ab_rdata", bus.rdata_out, 0);
      chk("ab_timeout", bus.timeout_err, 0);
      chk("ab_ready_r0", bus.ready_r0, 0);
      chk("ab_ready_r1", bus.ready_r1, 0);
      rstn = 1'b1;
      bus.read_r0 = 1'b1;
      bus.addr_r0 = 32'h700;
      tick();
      chk("ab_tie_r0", bus.addr_L2_MEM, 64'h700);
      chk("ab_no_ready_r1", bus.ready_r1, 0);
      bus.ready_MEM_L2 = 1'b1;
      bus.read_data_MEM_L2 = DataC;
      tick();
      chk("ab_r0_done", bus.ready_r0, 1);
      chk("ab_r1_wait", bus.ready_r1, 0);
      bus.ready_MEM_L2 = 1'b0;
      bus.read_r0 = 1'b0;
      bus.read_r1 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
